// File: rtl/f2_key_pkg.sv
// -----------------------------------------------------------------------------
// f2_key_pkg
// Shared definitions for the function-2 key front end:
//   - per-key FSM state type (IDLE / HELD_WAIT / HELD_REPEAT)
//   - default timing constants for the 50 MHz board
//   - counter-width helper sized so that no timing counter can ever wrap
// -----------------------------------------------------------------------------
package f2_key_pkg;

    // Per-key press/repeat FSM state.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HELD_WAIT   = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } key_state_e;

    // Default timing for a 50 MHz sysclk.
    localparam int DEF_NUM_KEYS        = 4;
    localparam int DEF_KEY_ACTIVE_LOW  = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

    // Width needed to hold the largest of the three timing limits.
    function automatic int cnt_width(input int debounce_cycles,
                                     input int repeat_delay,
                                     input int repeat_period);
        int max_v;
        max_v = debounce_cycles;
        if (repeat_delay > max_v) begin
            max_v = repeat_delay;
        end else begin
            max_v = max_v;
        end
        if (repeat_period > max_v) begin
            max_v = repeat_period;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage : f2_key_pkg

// File: rtl/f2_key_cell.sv
// -----------------------------------------------------------------------------
// f2_key_cell
// Single-key front end: 2-flop synchroniser, debounce counter and the
// press/auto-repeat FSM. The debounced level is implied by the FSM state
// (any held state == pressed), so there is no separate level flop.
//
// The cell exposes next-state values (level_d_o, pulse_d_o); the top level
// owns the output registers, so the pulse and the level rise appear on the
// same sysclk edge.
//
// Ports:
//   clk_i      sysclk
//   rst_i      asynchronous active-high reset
//   key_raw_i  raw, asynchronous button pin
//   level_d_o  next debounced pressed level (active-high)
//   pulse_d_o  next press/repeat pulse (active-high, one cycle per event)
// -----------------------------------------------------------------------------
module f2_key_cell
    import f2_key_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic level_d_o,
    output logic pulse_d_o
);

    // Pin level when the button is not pressed; synchroniser resets here so
    // reset never looks like a press.
    localparam logic RELEASED_LVL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_s;
    logic             level_s;
    logic             toggle_s;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    key_state_e       state_q;
    key_state_e       state_d;
    logic             pulse_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Normalise to pressed = 1.
    assign pressed_s = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Debounced level lives in the FSM: pressed exactly when not IDLE.
    assign level_s = (state_q != ST_IDLE);

    // Debounce: count cycles the synchronised input disagrees with the level;
    // any agreement restarts the count, reaching the limit flips the level.
    always_comb begin
        dcnt_d   = '0;
        toggle_s = 1'b0;
        if (pressed_s == level_s) begin
            dcnt_d   = '0;
            toggle_s = 1'b0;
        end else if (dcnt_q == DB_LAST) begin
            dcnt_d   = '0;
            toggle_s = 1'b1;
        end else begin
            dcnt_d   = dcnt_q + CNT_ONE;
            toggle_s = 1'b0;
        end
    end

    // Press/repeat FSM next state. In IDLE a toggle is a rising level, in a
    // held state it is a falling level; release always wins over a repeat.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rcnt_d = '0;
                if (toggle_s) begin
                    state_d = ST_HELD_WAIT;
                    pulse_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD_WAIT: begin
                if (toggle_s) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RD_LAST) begin
                    if (REPEAT_EN != 0) begin
                        state_d = ST_HELD_REPEAT;
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        // No auto-repeat: park with the counter saturated.
                        state_d = ST_HELD_WAIT;
                        rcnt_d  = rcnt_q;
                    end
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            ST_HELD_REPEAT: begin
                if (toggle_s) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RP_LAST) begin
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
                pulse_d = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level_d_o = (state_d != ST_IDLE);
    assign pulse_d_o = pulse_d;

endmodule : f2_key_cell

// File: rtl/f2_keydebounce.sv
// -----------------------------------------------------------------------------
// f2_keydebounce
// Function-2 key front end: synchronises and debounces NUM_KEYS raw buttons
// and produces one-cycle press pulses plus optional auto-repeat pulses for the
// downstream key-to-instruction translator.
//
// Ports:
//   sysclk      system clock (rising edge)
//   reset       asynchronous, active-high reset
//   keys_raw    raw button pins, asynchronous to sysclk
//   func2_keys  registered press/repeat pulses, one cycle wide, active-high
//   key_level   registered debounced pressed state, active-high
// -----------------------------------------------------------------------------
module f2_keydebounce
    import f2_key_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] func2_keys,
    output logic [NUM_KEYS-1:0] key_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    logic [NUM_KEYS-1:0] level_d;
    logic [NUM_KEYS-1:0] pulse_d;
    logic [NUM_KEYS-1:0] key_level_q;
    logic [NUM_KEYS-1:0] func2_keys_q;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        f2_key_cell #(
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk_i     (sysclk),
            .rst_i     (reset),
            .key_raw_i (keys_raw[gi]),
            .level_d_o (level_d[gi]),
            .pulse_d_o (pulse_d[gi])
        );
    end

    // Output registers: pulse and level rise land on the same edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            key_level_q  <= '0;
            func2_keys_q <= '0;
        end else begin
            key_level_q  <= level_d;
            func2_keys_q <= pulse_d;
        end
    end

    assign key_level  = key_level_q;
    assign func2_keys = func2_keys_q;

endmodule : f2_keydebounce

// File: tb/tb_f2_keydebounce.sv
module tb_f2_keydebounce;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          sysclk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] func2_keys, key_level;
    logic [NK-1:0] func2_keys_nr, key_level_nr;

    always #5 sysclk = ~sysclk;

    f2_keydebounce #(.NUM_KEYS(NK), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .sysclk(sysclk), .reset(reset), .keys_raw(keys_raw),
        .func2_keys(func2_keys), .key_level(key_level));

    f2_keydebounce #(.NUM_KEYS(NK), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_nr (
        .sysclk(sysclk), .reset(reset), .keys_raw(keys_raw),
        .func2_keys(func2_keys_nr), .key_level(key_level_nr));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model state
    logic [NK-1:0] m_s1, m_s2, m_lvl, m_pulse, m_pulse_nr;
    int            m_run   [NK];
    int            m_press [NK];

    // Observation helpers
    logic [NK-1:0] prev_lvl;
    int            rise_cyc [NK];
    logic [NK-1:0] rise_f2  [NK];
    int            pc    [NK];
    int            pc_nr [NK];

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model update and per-cycle comparison, 1 time unit after each edge.
    always @(posedge sysclk) begin
        int age;
        #1;
        cyc++;
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '0; m_pulse = '0; m_pulse_nr = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0; m_press[k] = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                // A level change needs DB consecutive edges of disagreement.
                if (~m_s2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k] = ~m_lvl[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) m_press[k] = cyc;
                    end
                end else begin
                    m_run[k] = 0;
                end
                age = cyc - m_press[k];
                m_pulse[k]    = m_lvl[k] && (age == 0 || (age >= RD && (age - RD) % RP == 0));
                m_pulse_nr[k] = m_lvl[k] && (age == 0);
            end
            m_s2 = m_s1;
            m_s1 = keys_raw;
        end
        chk("func2_keys", func2_keys, m_pulse);
        chk("key_level", key_level, m_lvl);
        chk("func2_keys_norep", func2_keys_nr, m_pulse_nr);
        chk("key_level_norep", key_level_nr, m_lvl);
        for (int k = 0; k < NK; k++) begin
            if (key_level[k] && !prev_lvl[k]) begin
                rise_cyc[k] = cyc;
                rise_f2[k]  = func2_keys;
            end
            if (!reset) begin
                pc[k]    += int'(func2_keys[k]);
                pc_nr[k] += int'(func2_keys_nr[k]);
            end
        end
        prev_lvl = key_level;
    end

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            pc[k] = 0; pc_nr[k] = 0;
        end
    endtask

    task automatic wait_rise(input int k, input int t0, input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (rise_cyc[k] > t0) begin
                lat = rise_cyc[k] - t0;
                break;
            end
        end
    endtask

    initial begin
        int t0, lat;
        prev_lvl = '0;
        for (int k = 0; k < NK; k++) begin
            rise_cyc[k] = 0; rise_f2[k] = '0; pc[k] = 0; pc_nr[k] = 0;
        end
        reset    = 1'b1;
        keys_raw = 4'b1111;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;

        // 1: idle keys after reset release
        clear_counts();
        repeat (50) @(negedge sysclk);
        chk_int("t1_pulses", pc[0] + pc[1] + pc[2] + pc[3], 0);
        chk("t1_level", key_level, 4'b0000);

        // 2: clean press of key 2
        clear_counts();
        t0 = cyc;
        keys_raw[2] = 1'b0;
        wait_rise(2, t0, 20, lat);
        chk_int("t2_latency", lat, 6);
        chk("t2_pulse_at_rise", rise_f2[2], 4'b0100);
        repeat (4) @(negedge sysclk);
        keys_raw[2] = 1'b1;
        repeat (20) @(negedge sysclk);
        chk_int("t2_pulse_count", pc[2], 1);

        // 3: bouncing key 0, then settle pressed
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            keys_raw[0] = 1'b0;
            repeat (2) @(negedge sysclk);
            keys_raw[0] = 1'b1;
            repeat (2) @(negedge sysclk);
        end
        chk_int("t3_bounce_pulses", pc[0], 0);
        t0 = cyc;
        keys_raw[0] = 1'b0;
        wait_rise(0, t0, 20, lat);
        chk_int("t3_latency", lat, 6);
        repeat (6) @(negedge sysclk);
        keys_raw[0] = 1'b1;
        repeat (20) @(negedge sysclk);
        chk_int("t3_pulse_count", pc[0], 1);

        // 4: long hold on key 3: press + repeats at 20,28,36,44,52
        clear_counts();
        keys_raw[3] = 1'b0;
        repeat (60) @(negedge sysclk);
        keys_raw[3] = 1'b1;
        repeat (20) @(negedge sysclk);
        chk_int("t4_repeat_count", pc[3], 6);
        chk_int("t4_norepeat_count", pc_nr[3], 1);
        chk("t4_released", key_level, 4'b0000);

        // 5: simultaneous press of keys 3 and 1
        clear_counts();
        t0 = cyc;
        keys_raw[3] = 1'b0;
        keys_raw[1] = 1'b0;
        wait_rise(1, t0, 20, lat);
        chk_int("t5_latency", lat, 6);
        chk("t5_simultaneous", rise_f2[1], 4'b1010);
        keys_raw[3] = 1'b1;
        repeat (25) @(negedge sysclk);

        // 6: reset while key 1 is auto-repeating and still held
        reset = 1'b1;
        #1;
        chk("t6_f2_in_reset", func2_keys, 4'b0000);
        chk("t6_lvl_in_reset", key_level, 4'b0000);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        clear_counts();
        t0 = cyc;
        wait_rise(1, t0, 20, lat);
        chk_int("t6_latency", lat, 6);
        repeat (29) @(negedge sysclk);
        chk_int("t6_repeat_count", pc[1], 3);
        chk_int("t6_norepeat_count", pc_nr[1], 1);
        keys_raw[1] = 1'b1;
        repeat (20) @(negedge sysclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_f2_keydebounce
